// File: rtl/cn_rst_seq_ctrl.sv
// Cold/warm reset and BIST sequencer for one controlled unit.
// Define CN_RST_SEQ_TIMEOUT_EN to enable the BIST watchdog (BIST_TO cycles).
module cn_rst_seq_ctrl #(
  parameter int DCOK_DLY = 16,
  parameter int RST_DLY  = 32,
  parameter int CLR_LEN  = 4,
  parameter int BIST_TO  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       skip_bist,
  input  logic       warm_rst_req,
  input  logic       bist_complete,
  output logic       dut_dcok,
  output logic       dut_rst_n,
  output logic       start_bist,
  output logic       clear_bist,
  output logic       busy,
  output logic       done,
  output logic       bist_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_RST_WAIT = 3'd2,
    S_BIST_RUN = 3'd3,
    S_BIST_CLR = 3'd4,
    S_READY    = 3'd5
  } state_t;

  // Counter is loaded with N-1 so the exit edge lands exactly N cycles after entry.
  localparam logic [CNT_W-1:0] DCOK_LD = CNT_W'(DCOK_DLY - 1);
  localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_DLY - 1);
  localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(CLR_LEN - 1);
  localparam logic [CNT_W-1:0] BIST_LD = CNT_W'(BIST_TO - 1);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             skip_q, skip_nxt;
  logic             start_nxt;
  logic             to_nxt;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    skip_nxt  = skip_q;
    start_nxt = 1'b0;
    to_nxt    = bist_timeout;
    if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_PWR_WAIT;
          cnt_nxt   = DCOK_LD;
          skip_nxt  = skip_bist;
          to_nxt    = 1'b0;
        end
      end
      S_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_nxt = S_RST_WAIT;
          cnt_nxt   = RST_LD;
        end
      end
      S_RST_WAIT: begin
        if (cnt_q == '0) state_nxt = skip_q ? S_READY : S_BIST_RUN;
      end
      // The first BIST_RUN cycle is a settle cycle; completion counts only once start_bist is up.
      S_BIST_RUN: begin
        if (!start_bist) begin
          start_nxt = 1'b1;
          cnt_nxt   = BIST_LD;
        end else if (bist_complete) begin
          state_nxt = S_BIST_CLR;
          cnt_nxt   = CLR_LD;
`ifdef CN_RST_SEQ_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          state_nxt = S_BIST_CLR;
          cnt_nxt   = CLR_LD;
          to_nxt    = 1'b1;
`endif
        end else begin
          start_nxt = 1'b1;
        end
      end
      S_BIST_CLR: begin
        if (cnt_q == '0) state_nxt = S_READY;
      end
      S_READY: begin
        state_nxt = S_READY;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (warm_rst_req && (state_q inside {S_RST_WAIT, S_BIST_RUN, S_BIST_CLR, S_READY})) begin
      state_nxt = S_RST_WAIT;
      cnt_nxt   = RST_LD;
      start_nxt = 1'b0;
    end
  end

  // Unit-facing levels are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      dut_dcok   <= 1'b0;
      dut_rst_n  <= 1'b0;
      start_bist <= 1'b0;
      clear_bist <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      skip_q     <= skip_nxt;
      dut_dcok   <= state_nxt inside {S_RST_WAIT, S_BIST_RUN, S_BIST_CLR, S_READY};
      dut_rst_n  <= state_nxt inside {S_BIST_RUN, S_BIST_CLR, S_READY};
      start_bist <= start_nxt;
      clear_bist <= (state_nxt == S_BIST_CLR);
      busy       <= state_nxt inside {S_PWR_WAIT, S_RST_WAIT, S_BIST_RUN, S_BIST_CLR};
      done       <= (state_nxt == S_READY);
    end
  end

`ifdef CN_RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bist_timeout <= 1'b0;
    else        bist_timeout <= to_nxt;
  end
`else
  assign bist_timeout = 1'b0;
`endif

  assign state = state_q;

endmodule
